// File: rtl/mdu_sequencer.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer producing HI/LO; every iteration step borrows
// the core's shared 32-bit ALU through alu_A/alu_B/alu_op instead of owning an adder.
module mdu_sequencer #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic             kill,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] resp_hi,
  output logic [WIDTH-1:0] resp_lo,
  output logic             busy,
  output logic [WIDTH-1:0] alu_A,
  output logic [WIDTH-1:0] alu_B,
  output logic [3:0]       alu_op,
  input  logic [WIDTH-1:0] alu_out
);

  localparam logic [3:0] AluAdd = 4'd0;
  localparam logic [3:0] AluSub = 4'd1;
  localparam logic [3:0] AluXxx = 4'd15;

  typedef enum logic [2:0] {StIdle, StPrep, StIter, StFixup, StDone} state_e;

  state_e             state_q, state_d;
  logic [1:0]         op_q, op_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               neg_quot_q, neg_quot_d;
  logic               neg_rem_q, neg_rem_d;
  logic               resp_valid_q, resp_valid_d;
  logic [WIDTH-1:0]   resp_hi_q, resp_hi_d;
  logic [WIDTH-1:0]   resp_lo_q, resp_lo_d;
  logic               carry;
  logic [WIDTH-1:0]   abs_a, abs_b;

  // During PREP the raw operands sit in lo_q (a) and mcand_q (b).
  assign abs_a = (op_q[0] && lo_q[WIDTH-1])    ? (~lo_q + 1'b1)    : lo_q;
  assign abs_b = (op_q[0] && mcand_q[WIDTH-1]) ? (~mcand_q + 1'b1) : mcand_q;

  assign req_ready  = (state_q == StIdle);
  assign busy       = (state_q != StIdle);
  assign resp_valid = resp_valid_q;
  assign resp_hi    = resp_hi_q;
  assign resp_lo    = resp_lo_q;

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    hi_d         = hi_q;
    lo_d         = lo_q;
    mcand_d      = mcand_q;
    cnt_d        = cnt_q;
    neg_quot_d   = neg_quot_q;
    neg_rem_d    = neg_rem_q;
    resp_valid_d = resp_valid_q;
    resp_hi_d    = resp_hi_q;
    resp_lo_d    = resp_lo_q;
    carry        = 1'b0;
    alu_A        = '0;
    alu_B        = '0;
    alu_op       = AluXxx;

    unique case (state_q)
      StIdle: begin
        if (req_valid && !kill) begin
          op_d    = req_op;
          lo_d    = req_a;
          mcand_d = req_b;
          state_d = StPrep;
        end
      end
      StPrep: begin
        neg_quot_d = op_q[0] & (lo_q[WIDTH-1] ^ mcand_q[WIDTH-1]);
        neg_rem_d  = op_q[0] & lo_q[WIDTH-1];
        cnt_d      = '0;
        hi_d       = '0;
        if (op_q[1]) begin
          if (mcand_q == '0) begin
            hi_d    = lo_q;
            lo_d    = '1;
            state_d = StDone;
          end else begin
            lo_d    = abs_a;
            mcand_d = abs_b;
            state_d = StIter;
          end
        end else begin
          lo_d    = abs_b;
          mcand_d = abs_a;
          state_d = StIter;
        end
      end
      StIter: begin
        alu_B = mcand_q;
        if (!op_q[1]) begin
          // Shift-add: hi accumulates, lo holds the multiplier and collects product bits.
          alu_op = AluAdd;
          alu_A  = hi_q;
          if (lo_q[0]) begin
            carry = (alu_A[WIDTH-1] & alu_B[WIDTH-1]) |
                    ((alu_A[WIDTH-1] | alu_B[WIDTH-1]) & ~alu_out[WIDTH-1]);
            hi_d  = {carry, alu_out[WIDTH-1:1]};
            lo_d  = {alu_out[0], lo_q[WIDTH-1:1]};
          end else begin
            hi_d = {1'b0, hi_q[WIDTH-1:1]};
            lo_d = {hi_q[0], lo_q[WIDTH-1:1]};
          end
        end else begin
          // Restoring divide: hi is the remainder, lo shifts dividend out and quotient in.
          alu_op = AluSub;
          alu_A  = {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};
          if (hi_q[WIDTH-1] || (alu_A >= alu_B)) begin
            hi_d = alu_out;
            lo_d = {lo_q[WIDTH-2:0], 1'b1};
          end else begin
            hi_d = alu_A;
            lo_d = {lo_q[WIDTH-2:0], 1'b0};
          end
        end
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = StFixup;
        end
      end
      StFixup: begin
        if (op_q == 2'b01 && neg_quot_q) begin
          {hi_d, lo_d} = ~{hi_q, lo_q} + 1'b1;
        end
        if (op_q == 2'b11) begin
          if (neg_quot_q) lo_d = ~lo_q + 1'b1;
          if (neg_rem_q)  hi_d = ~hi_q + 1'b1;
        end
        state_d = StDone;
      end
      StDone: begin
        if (!resp_valid_q) begin
          resp_valid_d = 1'b1;
          resp_hi_d    = hi_q;
          resp_lo_d    = lo_q;
        end else if (resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (kill) begin
      state_d      = StIdle;
      resp_valid_d = 1'b0;
      resp_hi_d    = resp_hi_q;
      resp_lo_d    = resp_lo_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      op_q         <= '0;
      hi_q         <= '0;
      lo_q         <= '0;
      mcand_q      <= '0;
      cnt_q        <= '0;
      neg_quot_q   <= 1'b0;
      neg_rem_q    <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_hi_q    <= '0;
      resp_lo_q    <= '0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      hi_q         <= hi_d;
      lo_q         <= lo_d;
      mcand_q      <= mcand_d;
      cnt_q        <= cnt_d;
      neg_quot_q   <= neg_quot_d;
      neg_rem_q    <= neg_rem_d;
      resp_valid_q <= resp_valid_d;
      resp_hi_q    <= resp_hi_d;
      resp_lo_q    <= resp_lo_d;
    end
  end

endmodule
